// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: controller states,
// opcodes and the select encodings of the datapath muxes.
package mips_pkg;

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Main Moore controller of the multicycle MIPS datapath: sequences each
// instruction through 2-5 states and drives every datapath enable and select.
module mc_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int OPW     = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPW-1:0]     op,
    input  logic               zero,
    output logic               pcen,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [1:0]         aluop,
    output logic [STATE_W-1:0] state_o
);

    state_t state;
    state_t state_next;
    logic   pcwrite;
    logic   branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
        end else begin
            state <= state_next;
        end
    end

    // Opcode is only consulted in DECODE and MEMADR; unknown opcodes fall back to FETCH.
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_RST:     state_next = S_FETCH;
            S_FETCH:   state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = S_MEMWB;
            S_EXECUTE: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = ALUSRCB_REGB;
        pcsrc    = PCSRC_ALU;
        aluop    = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alusrcb = ALUSRCB_FOUR;
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            S_DECODE: alusrcb = ALUSRCB_IMMSH;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        pcen = pcwrite | (branch & zero);
    end

    assign state_o = STATE_W'(state);

endmodule
